// File: rtl/w5_weight_buf.sv
// Weight buffer for w5: streams 256 signed bytes into 16 banks x 16 entries, serves 16 registered read ports.
// Optional load checksum enabled by defining W5_WBUF_CKSUM_EN.
module w5_weight_buf (
    input  logic        clk,
    input  logic        xrst,
    input  logic        load_start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        load_done,
    output logic        busy,
    input  logic [3:0]  w0_raddr,
    input  logic [3:0]  w1_raddr,
    input  logic [3:0]  w2_raddr,
    input  logic [3:0]  w3_raddr,
    input  logic [3:0]  w4_raddr,
    input  logic [3:0]  w5_raddr,
    input  logic [3:0]  w6_raddr,
    input  logic [3:0]  w7_raddr,
    input  logic [3:0]  w8_raddr,
    input  logic [3:0]  w9_raddr,
    input  logic [3:0]  w10_raddr,
    input  logic [3:0]  w11_raddr,
    input  logic [3:0]  w12_raddr,
    input  logic [3:0]  w13_raddr,
    input  logic [3:0]  w14_raddr,
    input  logic [3:0]  w15_raddr,
    output logic [7:0]  w0_rdata,
    output logic [7:0]  w1_rdata,
    output logic [7:0]  w2_rdata,
    output logic [7:0]  w3_rdata,
    output logic [7:0]  w4_rdata,
    output logic [7:0]  w5_rdata,
    output logic [7:0]  w6_rdata,
    output logic [7:0]  w7_rdata,
    output logic [7:0]  w8_rdata,
    output logic [7:0]  w9_rdata,
    output logic [7:0]  w10_rdata,
    output logic [7:0]  w11_rdata,
    output logic [7:0]  w12_rdata,
    output logic [7:0]  w13_rdata,
    output logic [7:0]  w14_rdata,
    output logic [7:0]  w15_rdata,
    output logic [15:0] cksum
);
    localparam int unsigned NBANK = 16;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned NWORD = NBANK * DEPTH;
    localparam int unsigned CW    = $clog2(NWORD);
    localparam int unsigned BW    = $clog2(NBANK);
    localparam int unsigned SW    = 16;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CW-1:0]     cnt_q;
    logic              accept;
    logic              last;
    logic              enter_load;
    logic [DW-1:0]     mem [NBANK][DEPTH];
    logic [AW-1:0]     raddr [NBANK];
    logic [DW-1:0]     rdata_q [NBANK];

    assign raddr[0]  = w0_raddr;
    assign raddr[1]  = w1_raddr;
    assign raddr[2]  = w2_raddr;
    assign raddr[3]  = w3_raddr;
    assign raddr[4]  = w4_raddr;
    assign raddr[5]  = w5_raddr;
    assign raddr[6]  = w6_raddr;
    assign raddr[7]  = w7_raddr;
    assign raddr[8]  = w8_raddr;
    assign raddr[9]  = w9_raddr;
    assign raddr[10] = w10_raddr;
    assign raddr[11] = w11_raddr;
    assign raddr[12] = w12_raddr;
    assign raddr[13] = w13_raddr;
    assign raddr[14] = w14_raddr;
    assign raddr[15] = w15_raddr;

    assign w0_rdata  = rdata_q[0];
    assign w1_rdata  = rdata_q[1];
    assign w2_rdata  = rdata_q[2];
    assign w3_rdata  = rdata_q[3];
    assign w4_rdata  = rdata_q[4];
    assign w5_rdata  = rdata_q[5];
    assign w6_rdata  = rdata_q[6];
    assign w7_rdata  = rdata_q[7];
    assign w8_rdata  = rdata_q[8];
    assign w9_rdata  = rdata_q[9];
    assign w10_rdata = rdata_q[10];
    assign w11_rdata = rdata_q[11];
    assign w12_rdata = rdata_q[12];
    assign w13_rdata = rdata_q[13];
    assign w14_rdata = rdata_q[14];
    assign w15_rdata = rdata_q[15];

    assign accept     = in_valid && (state_q == LOAD);
    assign last       = (cnt_q == CW'(NWORD - 1));
    assign enter_load = load_start && (state_q != LOAD);

    // State register
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; a start pulse during LOAD is ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_start) state_d = LOAD;
            LOAD:    if (accept && last) state_d = DONE;
            DONE:    if (load_start) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        load_done = 1'b0;
        case (state_q)
            LOAD:    begin in_ready = 1'b1; busy = 1'b1; end
            DONE:    load_done = 1'b1;
            default: ;
        endcase
    end

    // Word counter: low bits pick the bank, high bits the entry (address-major fill)
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst)           cnt_q <= '0;
        else if (enter_load) cnt_q <= '0;
        else if (accept)     cnt_q <= cnt_q + CW'(1);
    end

    // Storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (accept) mem[cnt_q[BW-1:0]][cnt_q[CW-1:BW]] <= in_data;
    end

    // Registered read ports; same-cycle write returns the old value
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            for (int n = 0; n < NBANK; n++) rdata_q[n] <= '0;
        end else begin
            for (int n = 0; n < NBANK; n++) rdata_q[n] <= mem[n][raddr[n]];
        end
    end

`ifdef W5_WBUF_CKSUM_EN
    logic [SW-1:0] sum_q;

    // Wrapping sum of sign-extended accepted bytes, cleared when a load begins
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst)           sum_q <= '0;
        else if (enter_load) sum_q <= '0;
        else if (accept)     sum_q <= sum_q + SW'($signed(in_data));
    end

    assign cksum = sum_q;
`else
    assign cksum = SW'(0);
`endif

endmodule

// File: tb/tb_w5_weight_buf.sv
// Directed bench for w5_weight_buf: table-driven reads plus load/reload/abort sequences.
module tb_w5_weight_buf;
    logic        clk;
    logic        xrst;
    logic        load_start;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        load_done;
    logic        busy;
    logic [3:0]  raddr [16];
    logic [7:0]  rdata [16];
    logic [15:0] cksum;

    logic [7:0]  model [256];
    int          total;
    int          bad;

    typedef struct {
        int         bank;
        logic [3:0] addr;
        logic [7:0] exp;
    } rd_vec_t;

    rd_vec_t vecs [8];

    w5_weight_buf dut (
        .clk(clk), .xrst(xrst), .load_start(load_start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .load_done(load_done), .busy(busy),
        .w0_raddr(raddr[0]),   .w1_raddr(raddr[1]),   .w2_raddr(raddr[2]),   .w3_raddr(raddr[3]),
        .w4_raddr(raddr[4]),   .w5_raddr(raddr[5]),   .w6_raddr(raddr[6]),   .w7_raddr(raddr[7]),
        .w8_raddr(raddr[8]),   .w9_raddr(raddr[9]),   .w10_raddr(raddr[10]), .w11_raddr(raddr[11]),
        .w12_raddr(raddr[12]), .w13_raddr(raddr[13]), .w14_raddr(raddr[14]), .w15_raddr(raddr[15]),
        .w0_rdata(rdata[0]),   .w1_rdata(rdata[1]),   .w2_rdata(rdata[2]),   .w3_rdata(rdata[3]),
        .w4_rdata(rdata[4]),   .w5_rdata(rdata[5]),   .w6_rdata(rdata[6]),   .w7_rdata(rdata[7]),
        .w8_rdata(rdata[8]),   .w9_rdata(rdata[9]),   .w10_rdata(rdata[10]), .w11_rdata(rdata[11]),
        .w12_rdata(rdata[12]), .w13_rdata(rdata[13]), .w14_rdata(rdata[14]), .w15_rdata(rdata[15]),
        .cksum(cksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] dat(input int mode, input int k);
        case (mode)
            0:       dat = 8'(k + 128);
            1:       dat = 8'h7F;
            default: dat = 8'hFF;
        endcase
    endfunction

    // Full or aborted load; the bench tracks acceptances itself and keeps the model/sum
    task automatic do_load(input int mode, input bit bursty, input int start_at,
                           input int abort_at, input bit rbw);
        logic [7:0]  old0;
        logic [15:0] sum;
        int          k;
        int          cyc;
        int          badrdy;
        old0 = model[0];
        sum = 16'h0;
        k = 0;
        cyc = 0;
        badrdy = 0;
        raddr[0] = 4'd0;
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        chk("start_done_low", 32'(load_done), 32'd0);
        chk("start_busy", 32'(busy), 32'd1);
        while (k < 256 && cyc < 4000) begin
            if (k == abort_at) begin
                in_valid = 1'b0;
                xrst = 1'b0;
                #1;
                chk("abort_done", 32'(load_done), 32'd0);
                chk("abort_ready", 32'(in_ready), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                @(posedge clk); #1;
                xrst = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                chk("abort_idle_ready", 32'(in_ready), 32'd0);
                chk("abort_idle_done", 32'(load_done), 32'd0);
                return;
            end
            in_valid = bursty ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data = dat(mode, k);
            load_start = (k == start_at) && in_valid;
            if (in_ready !== 1'b1 || busy !== 1'b1 || load_done !== 1'b0) badrdy++;
            @(posedge clk); #1;
            load_start = 1'b0;
            cyc++;
            if (in_valid) begin
                model[k] = in_data;
                sum = sum + 16'($signed(in_data));
                k++;
                if (rbw && k == 1) chk("rbw_old", 32'(rdata[0]), 32'(old0));
                if (rbw && k == 2) chk("rbw_new", 32'(rdata[0]), 32'(model[0]));
            end
        end
        in_valid = 1'b0;
        chk("handshake_during_load", 32'(badrdy), 32'd0);
        chk("accept_count", 32'(k), 32'd256);
        chk("done_after_last", 32'(load_done), 32'd1);
        chk("busy_after_last", 32'(busy), 32'd0);
        chk("ready_after_last", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("done_holds", 32'(load_done), 32'd1);
        chk("ready_in_done", 32'(in_ready), 32'd0);
`ifdef W5_WBUF_CKSUM_EN
        chk("cksum", 32'(cksum), 32'(sum));
`else
        chk("cksum_tied", 32'(cksum), 32'd0);
`endif
    endtask

    task automatic table_reads();
        for (int i = 0; i < 8; i++) begin
            raddr[vecs[i].bank] = vecs[i].addr;
            @(posedge clk); #1;
            chk("table_read", 32'(rdata[vecs[i].bank]), 32'(vecs[i].exp));
        end
    endtask

    task automatic par_reads();
        for (int c = 0; c < 16; c++) begin
            for (int n = 0; n < 16; n++) raddr[n] = 4'((n + c) % 16);
            @(posedge clk); #1;
            for (int n = 0; n < 16; n++)
                chk("par_read", 32'(rdata[n]), 32'(model[((n + c) % 16) * 16 + n]));
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        vecs[0] = '{3,  4'd2,  8'hA3};
        vecs[1] = '{15, 4'd15, 8'h7F};
        vecs[2] = '{0,  4'd0,  8'h80};
        vecs[3] = '{0,  4'd8,  8'h00};
        vecs[4] = '{7,  4'd4,  8'hC7};
        vecs[5] = '{9,  4'd1,  8'h99};
        vecs[6] = '{1,  4'd15, 8'h71};
        vecs[7] = '{12, 4'd7,  8'hFC};

        xrst = 1'b0;
        load_start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        for (int n = 0; n < 16; n++) raddr[n] = 4'd0;
        for (int k = 0; k < 256; k++) model[k] = 8'h00;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        for (int n = 0; n < 16; n++) chk("reset_rdata", 32'(rdata[n]), 32'd0);
        chk("reset_cksum", 32'(cksum), 32'd0);
        xrst = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("idle_ready", 32'(in_ready), 32'd0);
        chk("idle_done", 32'(load_done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Steady full load, then bursty reload with start coinciding with the last byte
        do_load(0, 1'b0, -1, -1, 1'b0);
        table_reads();
        do_load(0, 1'b1, 255, -1, 1'b0);
        table_reads();
        par_reads();

        // Start ignored mid-load, then reload of 0x7F from DONE
        do_load(0, 1'b0, 100, -1, 1'b0);
        do_load(1, 1'b0, -1, -1, 1'b1);
        par_reads();

        // Abort at 50, then a full 0xFF load
        do_load(2, 1'b0, -1, 50, 1'b0);
        do_load(2, 1'b1, -1, -1, 1'b0);
`ifdef W5_WBUF_CKSUM_EN
        chk("cksum_ff", 32'(cksum), 32'h0000FF00);
`endif
        par_reads();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
